// File: rtl/clr_skid_buffer.sv
// Two-entry valid/ready register slice with synchronous flush back to INI_DATA.
// One-cycle latency when empty, one beat per cycle; oRdy comes from state, never from iRdy.
module clr_skid_buffer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mainReg;
    logic [WIDTH-1:0] skidReg;
    logic             inFire;
    logic             outFire;

    assign inFire  = iVld & oRdy;
    assign outFire = oVld & iRdy;
    assign oDat    = mainReg;

    always_ff @(posedge clk) begin
        if (!rst || iClr) begin
            // Flush drops any beat offered this cycle; a beat leaving this cycle counts as delivered.
            state   <= EMPTY;
            mainReg <= INI_DATA;
            skidReg <= INI_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (inFire) begin
                        state   <= ONE;
                        mainReg <= iDat;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainReg <= iDat;
                    end else if (inFire) begin
                        state   <= FULL;
                        skidReg <= iDat;
                    end else if (outFire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        state   <= ONE;
                        mainReg <= skidReg;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_comb begin
        oVld = 1'b0;
        oRdy = 1'b1;
        oCnt = 2'd0;
        case (state)
            ONE: begin
                oVld = 1'b1;
                oCnt = 2'd1;
            end
            FULL: begin
                oVld = 1'b1;
                oRdy = 1'b0;
                oCnt = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clr_skid_buffer.sv
// Bench for clr_skid_buffer: directed scenarios plus random traffic against a queue model.
module tb_clr_skid_buffer;

    localparam int          W   = 32;
    localparam logic [31:0] INI = 32'h1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iClr = 1'b0;
    logic          iVld = 1'b0;
    logic          oRdy;
    logic [W-1:0]  iDat = '0;
    logic          oVld;
    logic          iRdy = 1'b0;
    logic [W-1:0]  oDat;
    logic [1:0]    oCnt;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    // Reference model: an ordered list of held beats, plus the value left on the output when empty.
    logic [W-1:0] mq[$];
    logic [W-1:0] emptyDat = INI;
    int           delivered = 0;

    clr_skid_buffer #(.WIDTH(W), .INI_DATA(INI)) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat),
        .oCnt (oCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit mIn, mOut;
        mIn  = iVld && (mq.size() < 2);
        mOut = (mq.size() > 0) && iRdy;
        if (!rst || iClr) begin
            if (rst && mOut) delivered++;
            mq.delete();
            emptyDat = INI;
        end else begin
            if (mOut) begin
                emptyDat = mq.pop_front();
                delivered++;
            end
            if (mIn) mq.push_back(iDat);
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            check("cmp_oVld", 32'(oVld), 32'(mq.size() > 0));
            check("cmp_oRdy", 32'(oRdy), 32'(mq.size() < 2));
            check("cmp_oCnt", 32'(oCnt), 32'(mq.size()));
            check("cmp_oDat", oDat, (mq.size() > 0) ? mq[0] : emptyDat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    initial begin
        // 1: reset
        tick();
        chkEn = 1'b1;
        tick();
        rst = 1'b1;
        check("rst_oVld", 32'(oVld), 32'd0);
        check("rst_oRdy", 32'(oRdy), 32'd1);
        check("rst_oCnt", 32'(oCnt), 32'd0);
        check("rst_oDat", oDat, 32'h1);

        // 2: streaming, one beat per cycle
        iRdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iVld = 1'b1;
            iDat = 32'h10 + 32'(i);
            tick();
            check("stream_oDat", oDat, 32'h10 + 32'(i));
            check("stream_oCnt", 32'(oCnt), 32'd1);
        end
        iVld = 1'b0;
        tick();
        check("stream_drain_oVld", 32'(oVld), 32'd0);

        // 3: backpressure A, B, C
        iRdy = 1'b0;
        iVld = 1'b1; iDat = 32'hA; tick();
        check("bp_A_oDat", oDat, 32'hA);
        iDat = 32'hB; tick();
        check("bp_full_oCnt", 32'(oCnt), 32'd2);
        check("bp_full_oRdy", 32'(oRdy), 32'd0);
        check("bp_model_size", 32'(mq.size()), 32'd2);
        iDat = 32'hC; tick();
        check("bp_hold_oDat", oDat, 32'hA);
        check("bp_hold_oCnt", 32'(oCnt), 32'd2);
        iRdy = 1'b1; tick();
        check("bp_B_oDat", oDat, 32'hB);
        check("bp_B_oRdy", 32'(oRdy), 32'd1);
        tick();
        check("bp_C_oDat", oDat, 32'hC);
        iVld = 1'b0; tick();
        check("bp_empty_oCnt", 32'(oCnt), 32'd0);

        // 4: flush while FULL, same-cycle beat D dropped
        iRdy = 1'b0;
        iVld = 1'b1; iDat = 32'h41; tick();
        iDat = 32'h42; tick();
        check("clr_full_oCnt", 32'(oCnt), 32'd2);
        iClr = 1'b1; iDat = 32'hD; tick();
        iClr = 1'b0; iVld = 1'b0;
        check("clr_oCnt", 32'(oCnt), 32'd0);
        check("clr_oDat", oDat, 32'h1);
        iRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_noD_oVld", 32'(oVld), 32'd0);
        end

        // 5: reset while FULL
        iRdy = 1'b0;
        iVld = 1'b1; iDat = 32'h51; tick();
        iDat = 32'h52; tick();
        rst = 1'b0; tick();
        rst = 1'b1;
        check("rstfull_oVld", 32'(oVld), 32'd0);
        check("rstfull_oCnt", 32'(oCnt), 32'd0);
        iDat = 32'h55; tick();
        check("rstfull_first_oDat", oDat, 32'h55);
        check("rstfull_first_oVld", 32'(oVld), 32'd1);
        iVld = 1'b0; iRdy = 1'b1; tick();

        // 6: random traffic
        delivered = 0;
        for (int i = 0; i < 2000; i++) begin
            iVld = 1'($urandom_range(0, 1));
            iRdy = 1'($urandom_range(0, 3) != 0);
            iClr = ($urandom_range(0, 31) == 0);
            iDat = $urandom;
            tick();
        end
        iClr = 1'b0; iVld = 1'b0;
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL rand_delivered got %0d expected >= 200", delivered);
        end
        tick();
        chkEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
